// File: rtl/gpu_reg_store_unit.sv
// Store/drain engine: waits for the tensor pipeline to retire, then streams a
// contiguous register range from a dedicated register-file read port to memory.
module gpu_reg_store_unit #(
    parameter int DATA_W   = 64,
    parameter int REG_AW   = 5,
    parameter int MEM_AW   = 16,
    parameter int PIPE_LAT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [REG_AW-1:0] cfg_reg_base,
    input  logic [REG_AW:0]   cfg_count,
    input  logic [MEM_AW-1:0] cfg_mem_base,
    input  logic              tensor_en,
    output logic [REG_AW-1:0] rf_rd_addr,
    input  logic [DATA_W-1:0] rf_rd_data,
    output logic              mem_wr_valid,
    input  logic              mem_wr_ready,
    output logic [MEM_AW-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_DRAIN = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_SEND  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam int DRAIN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(PIPE_LAT - 1);

    logic [2:0]         state_q,     state_d;
    logic [REG_AW-1:0]  reg_base_q,  reg_base_d;
    logic [REG_AW:0]    count_q,     count_d;
    logic [MEM_AW-1:0]  mem_base_q,  mem_base_d;
    logic [REG_AW:0]    rd_idx_q,    rd_idx_d;
    logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
    logic [REG_AW-1:0]  rd_addr_q,   rd_addr_d;
    logic               valid_q,     valid_d;
    logic [MEM_AW-1:0]  addr_q,      addr_d;
    logic [DATA_W-1:0]  data_q,      data_d;

    logic [REG_AW:0]    rd_idx_inc_s;
    logic [MEM_AW-1:0]  beat_addr_s;
    logic [REG_AW-1:0]  next_rd_addr_s;

    // Index arithmetic wraps naturally in the register and memory address widths.
    assign rd_idx_inc_s   = rd_idx_q + (REG_AW+1)'(1);
    assign beat_addr_s    = mem_base_q + MEM_AW'(rd_idx_q);
    assign next_rd_addr_s = reg_base_q + REG_AW'(rd_idx_inc_s);

    // Sequencer next-state and datapath load logic.
    always_comb begin
        state_d     = state_q;
        reg_base_d  = reg_base_q;
        count_d     = count_q;
        mem_base_d  = mem_base_q;
        rd_idx_d    = rd_idx_q;
        drain_cnt_d = drain_cnt_q;
        rd_addr_d   = rd_addr_q;
        valid_d     = valid_q;
        addr_d      = addr_q;
        data_d      = data_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    reg_base_d  = cfg_reg_base;
                    count_d     = cfg_count;
                    mem_base_d  = cfg_mem_base;
                    rd_idx_d    = {(REG_AW+1){1'b0}};
                    drain_cnt_d = {DRAIN_W{1'b0}};
                    if (cfg_count == {(REG_AW+1){1'b0}}) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                // Only an unbroken run of PIPE_LAT idle cycles proves write-backs landed.
                if (tensor_en) begin
                    drain_cnt_d = {DRAIN_W{1'b0}};
                end else if (drain_cnt_q == DRAIN_LAST) begin
                    state_d   = ST_LOAD;
                    rd_addr_d = reg_base_q;
                end else begin
                    drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
                end
            end
            ST_LOAD: begin
                data_d    = rf_rd_data;
                addr_d    = beat_addr_s;
                rd_idx_d  = rd_idx_inc_s;
                rd_addr_d = next_rd_addr_s;
                valid_d   = 1'b1;
                state_d   = ST_SEND;
            end
            ST_SEND: begin
                if (mem_wr_ready) begin
                    if (rd_idx_q < count_q) begin
                        data_d    = rf_rd_data;
                        addr_d    = beat_addr_s;
                        rd_idx_d  = rd_idx_inc_s;
                        rd_addr_d = next_rd_addr_s;
                    end else begin
                        valid_d   = 1'b0;
                        rd_addr_d = {REG_AW{1'b0}};
                        state_d   = ST_DONE;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_DONE: begin
                state_d     = ST_IDLE;
                rd_idx_d    = {(REG_AW+1){1'b0}};
                drain_cnt_d = {DRAIN_W{1'b0}};
            end
            default: begin
                state_d   = ST_IDLE;
                valid_d   = 1'b0;
                rd_addr_d = {REG_AW{1'b0}};
            end
        endcase
    end

    // State and datapath registers; reset abandons any transfer in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            reg_base_q  <= {REG_AW{1'b0}};
            count_q     <= {(REG_AW+1){1'b0}};
            mem_base_q  <= {MEM_AW{1'b0}};
            rd_idx_q    <= {(REG_AW+1){1'b0}};
            drain_cnt_q <= {DRAIN_W{1'b0}};
            rd_addr_q   <= {REG_AW{1'b0}};
            valid_q     <= 1'b0;
            addr_q      <= {MEM_AW{1'b0}};
            data_q      <= {DATA_W{1'b0}};
        end else begin
            state_q     <= state_d;
            reg_base_q  <= reg_base_d;
            count_q     <= count_d;
            mem_base_q  <= mem_base_d;
            rd_idx_q    <= rd_idx_d;
            drain_cnt_q <= drain_cnt_d;
            rd_addr_q   <= rd_addr_d;
            valid_q     <= valid_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
        end
    end

    assign rf_rd_addr   = rd_addr_q;
    assign mem_wr_valid = valid_q;
    assign mem_wr_addr  = addr_q;
    assign mem_wr_data  = data_q;
    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_DONE);

endmodule

// File: tb/tb_gpu_reg_store_unit.sv
// Directed table-driven bench for gpu_reg_store_unit with a behavioural register
// file and a beat-by-beat memory-side checker.
module tb_gpu_reg_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  cfg_reg_base = 5'd0;
    logic [5:0]  cfg_count = 6'd0;
    logic [15:0] cfg_mem_base = 16'd0;
    logic        tensor_en = 1'b0;
    logic [4:0]  rf_rd_addr;
    logic [63:0] rf_rd_data;
    logic        mem_wr_valid;
    logic        mem_wr_ready = 1'b1;
    logic [15:0] mem_wr_addr;
    logic [63:0] mem_wr_data;
    logic        busy;
    logic        done;

    logic [63:0] rf [32];
    logic [63:0] beat_data [32];
    int total = 0;
    int bad = 0;

    gpu_reg_store_unit #(.DATA_W(64), .REG_AW(5), .MEM_AW(16), .PIPE_LAT(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_reg_base(cfg_reg_base), .cfg_count(cfg_count), .cfg_mem_base(cfg_mem_base),
        .tensor_en(tensor_en), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
        .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always_comb rf_rd_data = rf[rf_rd_addr];

    typedef struct {
        string       name;
        logic [4:0]  base;
        logic [5:0]  cnt;
        logic [15:0] mbase;
        logic [7:0]  rpat;
        logic [7:0]  tpat;
        int          wb_cyc;
        logic [63:0] wb_val;
        int          restart_cyc;
        int          exp_beats;
        int          exp_first_valid;
        logic [15:0] exp_first_addr;
        logic [15:0] exp_last_addr;
        logic [63:0] exp_last_data;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic run_xfer(input vec_t v, output int beats, output int first_valid,
                            output logic [15:0] first_addr, output logic [15:0] last_addr,
                            output logic [63:0] last_data);
        int cyc, vcyc, done_at, last_hs, done_cnt;
        bit stall;
        logic rdy;
        logic [15:0] paddr, ea;
        logic [63:0] pdata;
        logic [4:0] ri;
        beats = 0; first_valid = -1; first_addr = 16'h0; last_addr = 16'h0; last_data = 64'h0;
        vcyc = 0; done_at = -1; last_hs = -1; done_cnt = 0; stall = 1'b0;
        paddr = 16'h0; pdata = 64'h0;
        @(negedge clk);
        cfg_reg_base = v.base; cfg_count = v.cnt; cfg_mem_base = v.mbase;
        start = 1'b1; tensor_en = 1'b0; mem_wr_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        chk({v.name, "_busy_on"}, {63'd0, busy}, 64'd1);
        while (done_cnt == 0 && cyc < 400) begin
            tensor_en = (cyc < 8) ? v.tpat[cyc] : 1'b0;
            if (cyc == v.wb_cyc) rf[3] = v.wb_val;
            if (cyc == v.restart_cyc) begin
                start = 1'b1; cfg_count = 6'd9; cfg_reg_base = 5'd0;
            end else begin
                start = 1'b0;
            end
            rdy = 1'b1;
            if (mem_wr_valid) begin
                rdy = v.rpat[vcyc % 8];
                vcyc++;
                if (first_valid < 0) first_valid = cyc;
                if (stall) begin
                    chk({v.name, "_hold_addr"}, {48'd0, mem_wr_addr}, {48'd0, paddr});
                    chk({v.name, "_hold_data"}, mem_wr_data, pdata);
                end
                if (rdy) begin
                    ri = v.base + 5'(beats);
                    ea = v.mbase + 16'(beats);
                    chk({v.name, "_beat_addr"}, {48'd0, mem_wr_addr}, {48'd0, ea});
                    chk({v.name, "_beat_data"}, mem_wr_data, rf[ri]);
                    if (beats == 0) first_addr = mem_wr_addr;
                    last_addr = mem_wr_addr;
                    last_data = mem_wr_data;
                    beat_data[beats % 32] = mem_wr_data;
                    beats++;
                    last_hs = cyc;
                end
                stall = !rdy;
                paddr = mem_wr_addr;
                pdata = mem_wr_data;
            end else begin
                stall = 1'b0;
            end
            mem_wr_ready = rdy;
            if (done) begin
                done_cnt++;
                done_at = cyc;
                chk({v.name, "_valid_low_in_done"}, {63'd0, mem_wr_valid}, 64'd0);
                chk({v.name, "_busy_in_done"}, {63'd0, busy}, 64'd1);
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; tensor_en = 1'b0; mem_wr_ready = 1'b1;
        if (done_cnt == 0) begin
            chk({v.name, "_timeout"}, 64'd0, 64'd1);
        end else begin
            chk({v.name, "_done_lat"}, 64'(done_at), (beats == 0) ? 64'd1 : 64'(last_hs + 1));
        end
        chk({v.name, "_done_drop"}, {63'd0, done}, 64'd0);
        chk({v.name, "_busy_drop"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        int nb, fv;
        logic [15:0] fa, la;
        logic [63:0] ld;

        for (int i = 0; i < 32; i++) rf[i] = 64'hDEAD_BEEF_0000_009E + 64'(i);
        for (int i = 0; i < 32; i++) beat_data[i] = 64'h0;

        //          name       base   cnt    mbase     rpat   tpat       wb  wb_val                 rs  beats fv  first     last      last_data
        vecs[0] = '{"basic",   5'd2,  6'd4,  16'h0100, 8'hFF, 8'h00,     0,  64'h0,                 0,  4,    5,  16'h0100, 16'h0103, 64'hDEAD_BEEF_0000_00A3};
        vecs[1] = '{"bkpress", 5'd2,  6'd4,  16'h0100, 8'hF4, 8'h00,     0,  64'h0,                 0,  4,    5,  16'h0100, 16'h0103, 64'hDEAD_BEEF_0000_00A3};
        vecs[2] = '{"wrap",    5'd30, 6'd4,  16'hFFFE, 8'hFF, 8'h00,     0,  64'h0,                 0,  4,    5,  16'hFFFE, 16'h0001, 64'hDEAD_BEEF_0000_009F};
        vecs[3] = '{"cnt32",   5'd7,  6'd32, 16'h2000, 8'hFF, 8'h00,     0,  64'h0,                 0,  32,   5,  16'h2000, 16'h201F, 64'hDEAD_BEEF_0000_00A4};
        vecs[4] = '{"cnt0",    5'd9,  6'd0,  16'h3000, 8'hFF, 8'h00,     0,  64'h0,                 0,  0,    -1, 16'h0000, 16'h0000, 64'h0};
        vecs[5] = '{"cnt1",    5'd31, 6'd1,  16'h7FFF, 8'h6D, 8'h00,     0,  64'h0,                 0,  1,    5,  16'h7FFF, 16'h7FFF, 64'hDEAD_BEEF_0000_00BD};
        vecs[6] = '{"restart", 5'd2,  6'd4,  16'h0100, 8'hFF, 8'h00,     0,  64'h0,                 6,  4,    5,  16'h0100, 16'h0103, 64'hDEAD_BEEF_0000_00A3};
        vecs[7] = '{"drain",   5'd2,  6'd4,  16'h0100, 8'hFF, 8'b1010,   6,  64'h3333_4444_5555_6666, 0, 4,   8,  16'h0100, 16'h0103, 64'hDEAD_BEEF_0000_00A3};

        // Reset values, checked while rst_n is still low.
        repeat (3) @(negedge clk);
        chk("rst_valid", {63'd0, mem_wr_valid}, 64'd0);
        chk("rst_busy",  {63'd0, busy}, 64'd0);
        chk("rst_done",  {63'd0, done}, 64'd0);
        chk("rst_addr",  {48'd0, mem_wr_addr}, 64'd0);
        chk("rst_data",  mem_wr_data, 64'd0);
        chk("rst_rfaddr", {59'd0, rf_rd_addr}, 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int k = 0; k < 8; k++) begin
            run_xfer(vecs[k], nb, fv, fa, la, ld);
            chk({vecs[k].name, "_beats"},      64'(nb), 64'(vecs[k].exp_beats));
            chk({vecs[k].name, "_first_vld"},  64'(fv), 64'(vecs[k].exp_first_valid));
            chk({vecs[k].name, "_first_addr"}, {48'd0, fa}, {48'd0, vecs[k].exp_first_addr});
            chk({vecs[k].name, "_last_addr"},  {48'd0, la}, {48'd0, vecs[k].exp_last_addr});
            chk({vecs[k].name, "_last_data"},  ld, vecs[k].exp_last_data);
            if (vecs[k].wb_cyc > 0) chk({vecs[k].name, "_wb_seen"}, beat_data[1], vecs[k].wb_val);
            repeat (2) @(negedge clk);
        end

        // Asynchronous reset while stalled in SEND.
        @(negedge clk);
        cfg_reg_base = 5'd2; cfg_count = 6'd4; cfg_mem_base = 16'h0100;
        start = 1'b1; mem_wr_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_pre_valid", {63'd0, mem_wr_valid}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_valid", {63'd0, mem_wr_valid}, 64'd0);
        chk("abort_busy",  {63'd0, busy}, 64'd0);
        chk("abort_done",  {63'd0, done}, 64'd0);
        @(negedge clk);
        mem_wr_ready = 1'b1;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", {62'd0, done, busy}, 64'd0);
        end

        // Clean transfer after the abort.
        run_xfer(vecs[0], nb, fv, fa, la, ld);
        chk("post_rst_beats", 64'(nb), 64'd4);
        chk("post_rst_first", 64'(fv), 64'd5);
        chk("post_rst_last",  {48'd0, la}, 64'h0103);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
